// File: rtl/kb_pkg.sv
// kb_pkg: shared definitions for the keyboard command path.
// Holds the decoder FSM state encoding, the 5-bit command constants, the
// scan codes of every mapped key and the scan-code -> command lookup.
package kb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } kb_state_t;

  // Break prefix, shared with kb_code
  localparam logic [7:0] BRK = 8'hF0;

  // Command codes beyond the sixteen hex digits
  localparam logic [4:0] CMD_ENTER = 5'd16;
  localparam logic [4:0] CMD_BKSP  = 5'd17;
  localparam logic [4:0] CMD_ESC   = 5'd18;
  localparam logic [4:0] CMD_SPACE = 5'd19;

  // Set-2 scan codes of the mapped keys
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef struct packed {
    logic       hit;
    logic [4:0] cmd;
  } kb_map_t;

  // Translate a scan code; hit=0 for keys the application does not use
  function automatic kb_map_t map_scan(input logic [7:0] sc);
    kb_map_t m;
    m.hit = 1'b1;
    m.cmd = 5'd0;
    case (sc)
      SC_0:     m.cmd = 5'd0;
      SC_1:     m.cmd = 5'd1;
      SC_2:     m.cmd = 5'd2;
      SC_3:     m.cmd = 5'd3;
      SC_4:     m.cmd = 5'd4;
      SC_5:     m.cmd = 5'd5;
      SC_6:     m.cmd = 5'd6;
      SC_7:     m.cmd = 5'd7;
      SC_8:     m.cmd = 5'd8;
      SC_9:     m.cmd = 5'd9;
      SC_A:     m.cmd = 5'd10;
      SC_B:     m.cmd = 5'd11;
      SC_C:     m.cmd = 5'd12;
      SC_D:     m.cmd = 5'd13;
      SC_E:     m.cmd = 5'd14;
      SC_F:     m.cmd = 5'd15;
      SC_ENTER: m.cmd = CMD_ENTER;
      SC_BKSP:  m.cmd = CMD_BKSP;
      SC_ESC:   m.cmd = CMD_ESC;
      SC_SPACE: m.cmd = CMD_SPACE;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/kb_cmd_fifo.sv
// kb_cmd_fifo: show-ahead circular FIFO with occupancy count.
// A push into a full FIFO is still taken when a pop happens in the same
// cycle, because the pop frees the slot. Popping an empty FIFO is ignored.
// head_data reads as zero while empty.
module kb_cmd_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  push_ok
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and count bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kb_cmd_decoder.sv
// kb_cmd_decoder: captures released-key scan codes from kb_code, acknowledges
// each one with a one-cycle var_ack pulse (the "var" line of kb_code), and
// queues the translated 5-bit command for the application FSM.
// Handshake: key_code is valid while listo=1; listo stays high until var_ack
// is seen; the FSM waits for listo to drop before it can capture again.
// Optional: define KB_DEDUP_EN to drop a repeat of the last pushed scan code
// that arrives within DEDUP_CYCLES clocks of that push.
module kb_cmd_decoder
  import kb_pkg::*;
#(
  parameter int DEPTH_LOG2   = 2,
  parameter int DEDUP_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          key_code,
  input  logic                listo,
  output logic                var_ack,
  input  logic                rd_en,
  output logic                cmd_valid,
  output logic [4:0]          cmd_code,
  output logic                fifo_full,
  output logic                overflow,
  output logic                unmapped,
  output logic [1:0]          dbg_state,
  output logic [DEPTH_LOG2:0] dbg_count
);

  if (DEDUP_CYCLES < 1) begin : g_bad_window
    $error("DEDUP_CYCLES must be at least 1");
  end

  kb_state_t  state;
  kb_state_t  state_n;
  logic [7:0] code_r;
  kb_map_t    map_r;
  logic       push_req;
  logic       push_ok;
  logic       fifo_empty;
  logic       dup_block;

  assign map_r     = map_scan(code_r);
  assign dbg_state = state;
  assign cmd_valid = !fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (listo) state_n = DECODE;
      DECODE:   state_n = ACK;
      ACK:      state_n = WAIT_LOW;
      WAIT_LOW: if (!listo) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Output decode: push or flag the captured code while in DECODE
  always_comb begin
    push_req = 1'b0;
    unmapped = 1'b0;
    if (state == DECODE) begin
      if (map_r.hit && !dup_block) push_req = 1'b1;
      if (!map_r.hit)              unmapped = 1'b1;
    end
  end

  // Capture register and registered acknowledge (high for the ACK cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      code_r  <= '0;
      var_ack <= 1'b0;
    end else begin
      if (state == IDLE && listo) code_r <= key_code;
      var_ack <= (state_n == ACK);
    end
  end

  // Sticky overflow: a translated command was refused by a full FIFO
  always_ff @(posedge clk) begin
    if (reset)                    overflow <= 1'b0;
    else if (push_req && !push_ok) overflow <= 1'b1;
  end

`ifdef KB_DEDUP_EN
  localparam int DW = $clog2(DEDUP_CYCLES + 1);
  logic [DW-1:0] dedup_cnt;
  logic [7:0]    last_code;

  assign dup_block = (code_r == last_code) && (dedup_cnt != '0);

  // Suppression window: reload on every accepted push, count down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      dedup_cnt <= '0;
      last_code <= '0;
    end else if (push_ok) begin
      dedup_cnt <= DW'(DEDUP_CYCLES);
      last_code <= code_r;
    end else if (dedup_cnt != '0) begin
      dedup_cnt <= dedup_cnt - 1'b1;
    end
  end
`else
  assign dup_block = 1'b0;
`endif

  kb_cmd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (5)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (map_r.cmd),
    .pop       (rd_en),
    .head_data (cmd_code),
    .count     (dbg_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

endmodule

// File: tb/tb_kb_cmd_decoder.sv
// tb_kb_cmd_decoder: directed scenarios plus a randomized key/pop mix,
// checked every cycle against a queue-based model of the command FIFO.
module tb_kb_cmd_decoder;
  import kb_pkg::*;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 4;
  localparam int DEDUP      = 100;
`ifdef KB_DEDUP_EN
  localparam bit DEDUP_ON = 1'b1;
`else
  localparam bit DEDUP_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          key_code = 8'h00;
  logic                listo = 1'b0;
  logic                var_ack;
  logic                rd_en = 1'b0;
  logic                cmd_valid;
  logic [4:0]          cmd_code;
  logic                fifo_full;
  logic                overflow;
  logic                unmapped;
  logic [1:0]          dbg_state;
  logic [DEPTH_LOG2:0] dbg_count;

  always #5 clk = ~clk;

  kb_cmd_decoder #(.DEPTH_LOG2(DEPTH_LOG2), .DEDUP_CYCLES(DEDUP)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_code  (key_code),
    .listo     (listo),
    .var_ack   (var_ack),
    .rd_en     (rd_en),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .unmapped  (unmapped),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int key_map[int];
  logic [4:0] exp_q[$];
  bit   m_ovf = 1'b0;
  bit   exp_push = 1'b0;
  logic [4:0] exp_cmd = '0;
  logic [7:0] exp_scan = '0;
  int   cyc = 0;
  bit   has_last = 1'b0;
  logic [7:0] last_c = '0;
  int   last_p = 0;

  initial begin
    logic [7:0] codes [20];
    codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
              8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h5A, 8'h66, 8'h76, 8'h29};
    for (int i = 0; i < 20; i++) key_map[int'(codes[i])] = i;
  end

  // FIFO contents evolve at each clock edge from the push/pop requests
  always @(posedge clk) begin
    bit do_pop;
    bit accept;
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_ovf    = 1'b0;
      has_last = 1'b0;
    end else begin
      do_pop = rd_en && (exp_q.size() > 0);
      accept = exp_push && ((exp_q.size() < DEPTH) || do_pop);
      if (exp_push && !accept) m_ovf = 1'b1;
      if (do_pop) void'(exp_q.pop_front());
      if (accept) begin
        exp_q.push_back(exp_cmd);
        has_last = 1'b1;
        last_c   = exp_scan;
        last_p   = cyc;
      end
    end
  end

  // Scoreboard: queue-visible outputs compared on every cycle
  always @(negedge clk) begin
    if (!reset) begin
      check("cmd_valid", cmd_valid, exp_q.size() != 0);
      check("cmd_code", cmd_code, (exp_q.size() != 0) ? exp_q[0] : 5'd0);
      check("fifo_full", fifo_full, exp_q.size() == DEPTH);
      check("count", dbg_count, exp_q.size());
      check("overflow", overflow, m_ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise(input logic [7:0] c);
    @(posedge clk); #1;
    listo    = 1'b1;
    key_code = c;
  endtask

  // Walks one handshake from cycle index 'start' (0 = cycle listo rose)
  task automatic observe(input logic [7:0] c, input int hold, input bit pop_dec, input int start);
    bit hit;
    bit dup;
    hit = key_map.exists(int'(c));
    for (int i = start; i <= 2 + hold; i++) begin
      @(negedge clk);
      check("var_ack", var_ack, i == 2);
      check("unmapped", unmapped, (i == 1) && !hit);
      if (i == 1) begin
        dup = DEDUP_ON && hit && has_last && (c == last_c) && ((cyc - last_p) < DEDUP);
        exp_push = hit && !dup;
        exp_cmd  = hit ? 5'(key_map[int'(c)]) : 5'd0;
        exp_scan = c;
        if (pop_dec) rd_en = 1'b1;
      end
      if (i == 2) begin
        exp_push = 1'b0;
        rd_en    = 1'b0;
      end
    end
    @(posedge clk); #1;
    listo    = 1'b0;
    key_code = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
  endtask

  task automatic send_key(input logic [7:0] c, input int hold, input bit pop_dec);
    raise(c);
    observe(c, hold, pop_dec, 0);
  endtask

  task automatic pop_once();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_drain [4];
    exp_drain = '{1, 2, 3, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_var", var_ack, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unmapped", unmapped, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // Single key: var on the third cycle, command 1 queued, popped away
    send_key(8'h16, 0, 0);
    @(negedge clk);
    check("t1_valid", cmd_valid, 1);
    check("t1_code", cmd_code, 1);
    pop_once();
    @(negedge clk);
    check("t1_empty", cmd_valid, 0);

    // Ordering: ENTER then A
    send_key(8'h5A, 0, 0);
    send_key(8'h1C, 0, 0);
    @(negedge clk);
    check("t2_first", cmd_code, 16);
    pop_once();
    @(negedge clk);
    check("t2_second", cmd_code, 10);
    pop_once();

    // Unmapped code: acknowledged, flagged, not queued
    send_key(8'h12, 0, 0);
    @(negedge clk);
    check("t3_valid", cmd_valid, 0);

    // Fill to full, then overflow
    send_key(8'h45, 0, 0);
    send_key(8'h16, 0, 0);
    send_key(8'h1E, 0, 0);
    send_key(8'h26, 0, 0);
    @(negedge clk);
    check("t4_full", fifo_full, 1);
    check("t4_no_ovf", overflow, 0);
    send_key(8'h25, 0, 0);
    @(negedge clk);
    check("t4_ovf", overflow, 1);
    check("t4_head", cmd_code, 0);
    send_key(8'h25, 0, 1);
    @(negedge clk);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_full_again", fifo_full, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_drain", cmd_code, exp_drain[i]);
      pop_once();
    end

    // listo held high long after the acknowledge
    send_key(8'h26, 20, 0);
    @(negedge clk);
    check("t5_one_entry", dbg_count, 1);
    pop_once();

    // Reset while in ACK with an entry already queued
    send_key(8'h3E, 0, 0);
    raise(8'h16);
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        exp_push = 1'b1;
        exp_cmd  = 5'd1;
        exp_scan = 8'h16;
      end
    end
    check("t6_in_ack", var_ack, 1);
    exp_push = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("t6_var_low", var_ack, 0);
    check("t6_idle", dbg_state, IDLE);
    check("t6_count", dbg_count, 0);
    check("t6_ovf_clr", overflow, 0);
    reset = 1'b0;
    observe(8'h16, 0, 0, 1);
    @(negedge clk);
    check("t6_recapture", cmd_code, 1);
    pop_once();

    if (DEDUP_ON) begin
      send_key(8'h45, 0, 0);
      idle(45);
      send_key(8'h45, 0, 0);
      pop_once();
      @(negedge clk);
      check("dd_blocked", cmd_valid, 0);
      idle(150);
      send_key(8'h45, 0, 0);
      @(negedge clk);
      check("dd_after", cmd_valid, 1);
      pop_once();
    end

    // Randomized mix of mapped/unmapped keys, holds and pops
    for (int n = 0; n < 120; n++) begin
      logic [7:0] c;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) c = 8'($urandom_range(0, 255));
      else          c = 8'(key_map.find_first_index(x) with (x == int'($urandom_range(0, 19)))[0]);
      send_key(c, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) pop_once();
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 30));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
